// File: rtl/fifo_push_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_push_arb_pkg: shared types and round-robin pick helper      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_push_arb_pkg;

  localparam int MAX_N  = 16;
  localparam int MAX_IW = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [MAX_IW-1:0] idx;
  } pick_t;

  // Rotate so ptr lands at bit 0, find the lowest set bit, map back to a requester index.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [MAX_IW-1:0] ptr,
                                    input int unsigned n);
    pick_t             res;
    logic [MAX_N-1:0]  rot;
    int unsigned       pos;
    res = '0;
    rot = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        pos    = (32'(ptr) + k) % n;
        rot[k] = req[pos[MAX_IW-1:0]];
      end
    end
    for (int unsigned k = MAX_N; k > 0; k--) begin
      if (rot[k-1]) begin
        pos     = (32'(ptr) + k - 1) % n;
        res.vld = 1'b1;
        res.idx = pos[MAX_IW-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_push_arb_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker: combinational round-robin winner search from ptr      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_picker
  import fifo_push_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 vld,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  pick_t pick;
  logic  unused_idx_bits;

  always_comb begin
    pick = rr_pick(MAX_N'(req), MAX_IW'(ptr), 32'(N));
  end

  assign vld             = pick.vld;
  assign idx             = pick.idx[IW-1:0];
  assign unused_idx_bits = ^pick.idx;

endmodule
`default_nettype wire

// File: rtl/fifo_push_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_push_arb: packet-locked round-robin FIFO push-port arbiter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         ack,
  input  logic                 full_r,
  output logic                 push,
  output logic [W-1:0]         push_data,
  output logic [$clog2(N)-1:0] owner_r,
  output logic                 locked_r,
  output logic                 err_len_r
);

  localparam int             IW       = $clog2(N);
  localparam int             CW       = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_BEATS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_q, err_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel_idx;
  logic          sel_req;
  logic          sel_last;
  logic          grant;

  rr_picker #(.N(N)) u_picker (
    .req (req),
    .ptr (rr_ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // While locked only the owner is eligible; reset and full both veto any push.
  always_comb begin
    sel_idx   = (state_q == LOCKED) ? owner_q : pick_idx;
    sel_req   = 1'b0;
    sel_last  = 1'b0;
    ack       = '0;
    push_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_req  = req[i];
        sel_last = req_last[i];
      end
    end
    grant = rst && !full_r && sel_req && ((state_q == LOCKED) || pick_vld);
    for (int i = 0; i < N; i++) begin
      if (grant && (sel_idx == IW'(i))) begin
        ack[i]    = 1'b1;
        push_data = req_data[i*W +: W];
      end
    end
    push = grant;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (grant) begin
      owner_d = sel_idx;
      if (sel_last) begin
        state_d    = IDLE;
        rr_ptr_d   = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
        beat_cnt_d = '0;
      end else if (state_q == IDLE) begin
        state_d    = LOCKED;
        beat_cnt_d = CW'(1);
      end else begin
        if (32'(beat_cnt_q) + 1 == MAX_BEATS) begin
          err_d = 1'b1;
        end
        if (beat_cnt_q != CNT_MAX) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign owner_r   = owner_q;
  assign locked_r  = (state_q == LOCKED);
  assign err_len_r = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_push_arb: scoreboard bench for fifo_push_arb             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fifo_push_arb;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXB = 16;
  localparam int IW   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic           full_r;
  logic           push;
  logic [W-1:0]   push_data;
  logic [IW-1:0]  owner_r;
  logic           locked_r;
  logic           err_len_r;

  always #5 clk = ~clk;

  fifo_push_arb #(.N(N), .W(W), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .ack       (ack),
    .full_r    (full_r),
    .push      (push),
    .push_data (push_data),
    .owner_r   (owner_r),
    .locked_r  (locked_r),
    .err_len_r (err_len_r)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } beat_t;

  // Per-requester pending beats as {last, data}
  logic [W:0] pq [N][$];
  beat_t      sb[$];
  beat_t      log_q[$];

  int errors = 0;
  int checks = 0;

  logic [N-1:0] en_mask;
  logic         drv_full;
  logic         drv_rst;
  bit           chk_en;

  // Reference view of the arbiter, expressed in terms of packets
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_len;
  bit m_err;
  bit s_locked;
  int s_owner;
  bit s_err;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_len    = 0;
    m_err    = 0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += pq[i].size();
    return n;
  endfunction

  task automatic add_pkt(input int r, input int len, input int base);
    for (int b = 0; b < len; b++) pq[r].push_back({(b == len - 1), W'(base + b)});
  endtask

  task automatic cycle();
    int         w;
    bit         g;
    logic [W:0] b;
    @(negedge clk);
    rst    = drv_rst;
    full_r = drv_full;
    for (int i = 0; i < N; i++) begin
      req[i]            = en_mask[i] && (pq[i].size() > 0);
      req_data[i*W +: W] = req[i] ? pq[i][0][W-1:0] : W'($urandom());
      req_last[i]       = req[i] ? pq[i][0][W] : ($urandom_range(0, 1) == 1);
    end
    s_locked = m_locked;
    s_owner  = m_owner;
    s_err    = m_err;
    g = 0;
    w = 0;
    if (drv_rst && !drv_full) begin
      if (m_locked) begin
        g = req[m_owner];
        w = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!g && req[(m_ptr + k) % N]) begin
            g = 1;
            w = (m_ptr + k) % N;
          end
        end
      end
    end
    if (g) begin
      b = pq[w].pop_front();
      sb.push_back('{idx: IW'(w), data: b[W-1:0]});
      m_len++;
      m_owner = w;
      if (b[W]) begin
        m_locked = 0;
        m_ptr    = (w + 1) % N;
        m_len    = 0;
      end else begin
        m_locked = 1;
        if (m_len == MAXB) m_err = 1;
      end
    end
    if (!drv_rst) model_reset();
  endtask

  task automatic do_reset();
    drv_rst = 0;
    cycle();
    drv_rst = 1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check(pending() == 0, "drain_timeout", pending(), 0);
  endtask

  task automatic log_is(input int pos, input int idx, input int data, input string nm);
    logic [63:0] got;
    got = (pos < log_q.size()) ? 64'(log_q[pos]) : 64'hFFFF_FFFF_FFFF_FFFF;
    check(got == 64'({IW'(idx), W'(data)}), nm, got, {IW'(idx), W'(data)});
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every DUT push
  always @(negedge clk) begin
    beat_t e;
    int    aidx;
    #2;
    if (chk_en) begin
      check((push == (ack != '0)) && $onehot0(ack), "push_vs_ack", {ack, push}, 0);
      check(owner_r == IW'(s_owner), "owner_r", owner_r, s_owner);
      check(locked_r == s_locked, "locked_r", locked_r, s_locked);
      check(err_len_r == s_err, "err_len_r", err_len_r, s_err);
      if (push) begin
        check(sb.size() > 0, "push_expected", push, 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check(ack == N'(1 << e.idx), "ack", ack, 1 << e.idx);
          check(push_data == e.data, "push_data", push_data, e.data);
        end
        aidx = 0;
        for (int i = 0; i < N; i++) if (ack[i]) aidx = i;
        log_q.push_back('{idx: IW'(aidx), data: push_data});
      end else begin
        check(push_data == '0, "push_data_idle", push_data, 0);
        check(sb.size() == 0, "missed_push", sb.size(), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    full_r   = 0;
    en_mask  = '1;
    drv_full = 0;
    drv_rst  = 0;
    chk_en   = 0;
    model_reset();
    cycle();
    chk_en = 1;
    cycle();
    drv_rst = 1;

    // Single-beat fairness
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, 'h100 + i * 16 + k);
    log_q.delete();
    repeat (5) cycle();
    #3;
    log_is(0, 0, 'h100, "fair0");
    log_is(1, 1, 'h110, "fair1");
    log_is(2, 2, 'h120, "fair2");
    log_is(3, 3, 'h130, "fair3");
    log_is(4, 0, 'h101, "fair4");
    drain(50);

    // Packet lock against a competing requester
    do_reset();
    add_pkt(0, 3, 'hA0);
    add_pkt(2, 1, 'hC0);
    add_pkt(2, 1, 'hC1);
    en_mask = 4'b0101;
    log_q.delete();
    repeat (4) cycle();
    #3;
    log_is(0, 0, 'hA0, "lock0");
    log_is(1, 0, 'hA1, "lock1");
    log_is(2, 0, 'hA2, "lock2");
    log_is(3, 2, 'hC0, "lock3");
    drain(50);

    // Backpressure mid-packet
    do_reset();
    add_pkt(1, 4, 'hB0);
    en_mask = 4'b0010;
    log_q.delete();
    cycle();
    drv_full = 1;
    repeat (5) cycle();
    drv_full = 0;
    drain(50);
    #3;
    check(log_q.size() == 4, "bp_count", log_q.size(), 4);
    for (int b = 0; b < 4; b++) log_is(b, 1, 'hB0 + b, "bp_order");

    // Owner bubble
    do_reset();
    add_pkt(3, 4, 'hD0);
    add_pkt(0, 1, 'hE0);
    log_q.delete();
    en_mask = 4'b1000;
    cycle();
    en_mask = 4'b0001;
    repeat (2) cycle();
    en_mask = 4'b1001;
    drain(50);
    #3;
    for (int b = 0; b < 4; b++) log_is(b, 3, 'hD0 + b, "bubble_owner");
    log_is(4, 0, 'hE0, "bubble_next");

    // Over-length packet then a legal one
    do_reset();
    en_mask = '1;
    add_pkt(1, 20, 'h5000);
    add_pkt(1, 2, 'h6000);
    drain(100);
    cycle();
    #3;
    check(err_len_r == 1'b1, "err_sticky", err_len_r, 1);
    do_reset();
    cycle();
    #3;
    check(err_len_r == 1'b0, "err_cleared", err_len_r, 0);

    // Reset in the middle of a packet
    add_pkt(2, 4, 'h700);
    en_mask = 4'b0100;
    log_q.delete();
    repeat (2) cycle();
    add_pkt(0, 1, 'hF0);
    en_mask = 4'b0101;
    do_reset();
    cycle();
    #3;
    log_is(0, 2, 'h700, "rst_pre0");
    log_is(1, 2, 'h701, "rst_pre1");
    log_is(2, 0, 'hF0, "rst_first_grant");
    drain(50);

    // Randomized traffic with random backpressure and bubbles
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
          add_pkt(i, ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 5),
                  int'($urandom()));
      end
      for (int i = 0; i < N; i++) en_mask[i] = ($urandom_range(0, 7) != 0);
      drv_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    en_mask  = '1;
    drv_full = 0;
    drain(600);
    cycle();
    #3;
    check(sb.size() == 0, "sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
